// File: rtl/priority_encoder_seq.sv
// Registered priority encoder: captures an N-bit request vector, then emits one index per beat.
// Optional build macro PRIO_LSB_FIRST_EN selects lowest-index-first ordering.
//
// state | meaning
// IDLE  | ready to capture a request vector, no beat offered
// BUSY  | emitting beats for the captured vector, capture blocked
module priority_encoder_seq #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);

    if (N < 2 || N > 64 || IDX_W != $clog2(N)) begin : g_bad_param
        $error("priority_encoder_seq: N must be 2..64 and IDX_W must equal clog2(N)");
    end

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pend_q, pend_d;
    logic             zflag_q, zflag_d;
    logic [IDX_W-1:0] win_idx;
    logic             single;
    logic [N-1:0]     clr_mask;

    always_comb begin
        win_idx = '0;
`ifdef PRIO_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) win_idx = IDX_W'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (pend_q[i]) win_idx = IDX_W'(i);
        end
`endif
    end

    // At most one bit set means the current beat drains the vector.
    assign single   = ((pend_q & (pend_q - N'(1))) == '0);
    assign clr_mask = N'(1) << win_idx;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        zflag_d   = zflag_q;
        req_ready = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    pend_d  = req;
                    zflag_d = (req == '0);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                out_valid = 1'b1;
                out_idx   = win_idx;
                out_last  = single;
                out_zero  = zflag_q;
                if (out_ready) begin
                    if (single) begin
                        pend_d  = '0;
                        zflag_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        pend_d = pend_q & ~clr_mask;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zflag_q <= zflag_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: vector table plus scoreboard of expected beats.
module tb_priority_encoder_seq;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [N-1:0]     req;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_zero;

    priority_encoder_seq #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             zero;
    } beat_t;

    typedef struct {
        logic [N-1:0] vec;
        int           beats;
        bit           rnd_ready;
    } vec_t;

    beat_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    beats_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ordering of beats for one captured vector.
    task automatic push_model(input logic [N-1:0] v);
        int    remaining;
        beat_t b;
        remaining = $countones(v);
        if (v == '0) begin
            b.idx = '0; b.last = 1'b1; b.zero = 1'b1;
            sb_q.push_back(b);
        end else begin
            for (int k = 0; k < N; k++) begin
`ifdef PRIO_LSB_FIRST_EN
                int i = k;
`else
                int i = N - 1 - k;
`endif
                if (v[i]) begin
                    b.idx  = IDX_W'(i);
                    b.last = (remaining == 1);
                    b.zero = 1'b0;
                    sb_q.push_back(b);
                    remaining--;
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs driven; resolves handshakes and advances one cycle.
    task automatic tick();
        bit    cap, hs;
        beat_t exp_b;
        cap = req_valid && req_ready;
        hs  = out_valid && out_ready;
        if (cap) push_model(req);
        if (hs) begin
            beats_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_beat", {29'd0, out_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_b = sb_q.pop_front();
                check("beat", {27'd0, out_idx, out_last, out_zero}, {27'd0, exp_b});
            end
        end
        @(posedge clk);
        #1;
        if (cap) check("first_beat_latency", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_vector(input logic [N-1:0] v, input int exp_beats, input bit rnd);
        beats_seen = 0;
        req_valid  = 1'b1;
        req        = v;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (sb_q.size() == 0 && req_ready) break;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("beat_count", beats_seen, exp_beats);
        check("idle_after", {30'd0, req_ready, out_valid}, 32'd2);
        check("sb_empty", sb_q.size(), 0);
    endtask

    vec_t tbl[$];
    logic [IDX_W-1:0] bp_idx;

    initial begin
        tbl.push_back('{8'b1010_0100, 3, 1'b0});
        tbl.push_back('{8'h00, 1, 1'b0});
        tbl.push_back('{8'h01, 1, 1'b0});
        tbl.push_back('{8'h80, 1, 1'b0});
        tbl.push_back('{8'hFF, 8, 1'b0});
        tbl.push_back('{8'h3C, 4, 1'b1});
        tbl.push_back('{8'h55, 4, 1'b1});
        tbl.push_back('{8'hFF, 8, 1'b1});
        tbl.push_back('{8'h00, 1, 1'b1});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, req_ready, out_valid, out_idx, out_last, out_zero}, {27'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Idle with out_ready high must stay quiet.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("idle_quiet", {29'd0, req_ready, out_valid, out_zero}, 32'd4);
            tick();
        end
        out_ready = 1'b0;

        foreach (tbl[t]) run_vector(tbl[t].vec, tbl[t].beats, tbl[t].rnd_ready);

        // Backpressure: beat must hold, and traffic on req is ignored while busy.
`ifdef PRIO_LSB_FIRST_EN
        bp_idx = 3'd0;
`else
        bp_idx = 3'd7;
`endif
        beats_seen = 0;
        req_valid  = 1'b1;
        req        = 8'h81;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1;
            req       = 8'hFF;
            check("bp_hold", {26'd0, out_valid, out_idx, out_last, req_ready}, {26'd0, 1'b1, bp_idx, 1'b0, 1'b0});
            tick();
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (sb_q.size() == 0 && req_ready) break;
            tick();
        end
        out_ready = 1'b0;
        check("bp_beat_count", beats_seen, 2);
        check("bp_sb_empty", sb_q.size(), 0);

        // Asynchronous reset mid-stream discards pending bits.
        beats_seen = 0;
        req_valid  = 1'b1;
        req        = 8'hFF;
        tick();
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("mid_beats_before_reset", beats_seen, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {27'd0, req_ready, out_valid, out_idx, out_last, out_zero}, {27'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beats_seen = 0;
        for (int k = 0; k < 4; k++) begin
            check("no_stale_beat", {30'd0, req_ready, out_valid}, 32'd2);
            tick();
        end
        out_ready = 1'b0;

        run_vector(8'b1010_0100, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
